uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Shared UART transmitter sequencer that consumes the 16x oversample square wave from the baud clock divider and owns the single TX pin. It arbitrates round-robin between two byte requesters. The granted byte is framed as start, data LSB-first, [parity], stop, and shifted out with every bit exactly OVERSAMPLE tick periods long. It sits between the USB pass-through byte sources and the FPGA TX pad.

## Interface
- OVERSAMPLE, 16: tick rising edges per bit; legal 2..256.
- DATA_BITS, 8: data bits per frame; legal 5..8.
- clk  input  1  system clock (12 MHz).
- rst  input  1  asynchronous, active-low reset.
- tick_in  input  1  divider square-wave output, synchronous to clk; only rising edges are used.
- req0  input  1  requester 0 has a byte; hold high with data0 stable until ack0.
- data0  input  DATA_BITS  requester 0 byte.
- ack0  output  1  one-cycle pulse: data0 captured.
- req1, data1, ack1: same as above, for requester 1.
- txd  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line.
- grant  output  1  source of the current or last frame (0/1).

## Operation
- Tick edge: `tick_q` is tick_in registered once. `tick_edge = tick_in & ~tick_q`, evaluated combinationally in the same cycle.
- States: IDLE, START, DATA, PAR (only with the macro), STOP.
- IDLE: on a cycle with tick_edge and (req0|req1), the block chooses a winner and does the following at that clk edge:
  - loads the shift register;
  - pulses ackN;
  - sets grant;
  - enters START with txd=0, busy=1, sample counter=0.
- Arbitration:
  - If only one requester is high, it wins.
  - If both are high, the requester not granted last wins.
  - After reset, requester 0 wins the first tie.
- Bit pacing: each tick_edge increments the sample counter (width clog2(OVERSAMPLE)). On the tick_edge with counter == OVERSAMPLE-1, the counter wraps to 0 and the state advances.
- START → DATA: txd = shift[0]; shift right once per bit; bit counter counts to DATA_BITS-1.
- DATA → STOP (or PAR): after the last data bit; txd=1 in STOP.
- STOP end (final tick_edge):
  - If any req is high: arbitrate and go directly to START on that edge (back-to-back frames, no idle gap).
  - Otherwise: IDLE, busy=0.
- Requests arriving mid-frame wait; ack never pulses outside the frame-start edge.
- A requester raising req again after ack supplies a new byte.
- Dropping req before ack withdraws it without error.

## Timing
- Reset values: txd=1, busy=0, ack0=ack1=0, grant=0, state IDLE, all counters 0, round-robin pointer favours requester 0.
- Reset mid-frame: txd returns to 1 asynchronously and the frame is abandoned. The byte is not re-sent because its ack already fired.
- Start latency: txd falls on the first tick_edge with a pending request. Worst case is one tick period plus 0 cycles.
- ackN is high exactly one clk cycle, coincident with the first cycle of txd=0.
- Bit length: exactly OVERSAMPLE tick periods. At 12 MHz with a 78-clk tick this is 1248 clk.
- Frame length: (DATA_BITS+2[+1]) × OVERSAMPLE tick periods.
- All outputs are registered.
- tick_in held constant: the block freezes in its current state, with no timeout.

## Configuration
- UART_TX_PARITY_EN defined:
  - PAR state is inserted between DATA and STOP.
  - txd carries even parity (XOR of the data bits) for one bit time.
  - Frame length grows by OVERSAMPLE tick periods.
- UART_TX_PARITY_EN undefined: no PAR state; the frame is start + DATA_BITS + stop.

## Test plan
- Single byte: reset → req0=1, data0=0xA5, 78-clk tick → ack0 single pulse at first tick edge. txd shows 0,1,0,1,0,0,1,0,1,1, each bit 1248 clk. busy then drops and grant=0.
- Tie: req0 and req1 high from reset with 0x11 and 0x22 → frames on the line in order 0x11, 0x22, 0x11, 0x22, with grant alternating. No idle gap between the stop bit and the next start bit.
- Mid-frame request: req1 raised during the DATA of a requester-0 frame → ack1 stays 0 until the stop bit's final tick edge, then pulses. txd falls on that same clk edge.
- Reset mid-frame: assert rst low in the 4th data bit → txd=1, busy=0, ack=0 immediately. After release, the next frame starts cleanly and requester 0 wins any tie.
- Parity, with UART_TX_PARITY_EN: data0=0x07 → parity bit 1, frame 11 bits. data0=0x03 → parity bit 0.
- Stalled tick: hold tick_in low for 5000 clk during START → txd stays 0 and the state is unchanged. The start bit resumes on restart and completes after the remaining tick edges.

Source files
------------

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester round-robin UART transmitter paced by an oversample tick
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_arb #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 txd,
  output logic                 busy,
  output logic                 grant
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 txd_n, busy_n, ack0_n, ack1_n, grant_n;
  logic                 rr, rr_n;
  logic                 tick_q;
  logic                 tick_edge, bit_end, any_req, win, launch;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  assign tick_edge = tick_in & ~tick_q;
  assign bit_end   = tick_edge && (cnt == CNT_LAST);
  assign any_req   = req0 | req1;
  // rr names the requester that wins the next tie
  assign win       = req1 & (~req0 | rr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      txd    <= 1'b1;
      busy   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      grant  <= 1'b0;
      rr     <= 1'b0;
      tick_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      txd    <= txd_n;
      busy   <= busy_n;
      ack0   <= ack0_n;
      ack1   <= ack1_n;
      grant  <= grant_n;
      rr     <= rr_n;
      tick_q <= tick_in;
`ifdef UART_TX_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    txd_n    = txd;
    busy_n   = busy;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    grant_n  = grant;
    rr_n     = rr;
    launch   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n    = par;
`endif

    if (tick_edge) begin
      if (state != S_IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: launch = any_req;
        S_START: begin
          if (bit_end) begin
            state_n  = S_DATA;
            txd_n    = shift[0];
            shift_n  = shift >> 1;
            bitcnt_n = '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bitcnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_n = S_PAR;
              txd_n   = par;
`else
              state_n = S_STOP;
              txd_n   = 1'b1;
`endif
            end else begin
              bitcnt_n = bitcnt + 3'd1;
              txd_n    = shift[0];
              shift_n  = shift >> 1;
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            // a pending request chains straight into the next start bit
            if (any_req) begin
              launch = 1'b1;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (launch) begin
      state_n  = S_START;
      cnt_n    = '0;
      bitcnt_n = '0;
      shift_n  = win ? data1 : data0;
      ack0_n   = ~win;
      ack1_n   = win;
      grant_n  = win;
      rr_n     = ~win;
      txd_n    = 1'b0;
      busy_n   = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_n    = win ? ^data1 : ^data0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed and randomized frame checks for uart_tx_arb
module tb_uart_tx_arb;

  localparam int OS    = 4;
  localparam int DB    = 8;
  localparam int TP    = 6;
  localparam int B     = OS * TP;
  localparam int STALL = 5000;
`ifdef UART_TX_PARITY_EN
  localparam int FB = DB + 3;
`else
  localparam int FB = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick_in = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [DB-1:0] data0 = '0;
  logic [DB-1:0] data1 = '0;
  logic          ack0, ack1, txd, busy, grant;

  bit tick_run = 1'b1;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int prev_src = 1;

  uart_tx_arb #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .txd(txd), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Square wave of period TP clocks; pausing freezes its phase so a stall shifts it whole
  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      if (tick_run) begin
        tcnt++;
        if (tcnt == TP / 2) begin
          tcnt = 0;
          tick_in = ~tick_in;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [DB-1:0] d);
    if (r == 0) begin req0 = 1'b1; data0 = d; end
    else        begin req1 = 1'b1; data1 = d; end
  endtask

  task automatic drop_req(input int r);
    if (r == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'({ack1, ack0}), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    rst = 1'b1;
    prev_src = 1;
    @(negedge clk);
  endtask

  // Waits for a start bit, then checks the whole frame cycle by cycle against the
  // expected serial image; ends one cycle after the stop bit.
  task automatic run_frame(input int src, input logic [DB-1:0] byt, input bit b2b,
                           input bit keep, input int raise_at, input logic [DB-1:0] raise_data,
                           input int stall_at, input int rst_at);
    logic [FB-1:0] bits;
    int w, bit_err, ack_err, busy_err, stall_err;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[i+1] = byt[i];
`ifdef UART_TX_PARITY_EN
    bits[DB+1] = ^byt;
`endif
    bits[FB-1] = 1'b1;
    w = 0; bit_err = 0; ack_err = 0; busy_err = 0; stall_err = 0;
    while (txd !== 1'b0 && w < 3 * TP) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", 32'(txd), 32'd0);
    if (txd !== 1'b0) return;
    if (b2b) check("b2b_gap", 32'(w), 32'd0);
    check("ack_own", 32'(src != 0 ? ack1 : ack0), 32'd1);
    check("ack_other", 32'(src != 0 ? ack0 : ack1), 32'd0);
    check("grant", 32'(grant), 32'(src));
    prev_src = src;
    if (!keep) drop_req(src);
    for (int c = 0; c < FB * B; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (ack0 || ack1) ack_err++;
      end
      if (txd !== bits[c / B]) bit_err++;
      if (busy !== 1'b1) busy_err++;
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'({ack1, ack0}), 32'd0);
        prev_src = 1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      if (c == raise_at) set_req(1, raise_data);
      if (c == stall_at) begin
        @(posedge clk);
        tick_run = 1'b0;
        repeat (STALL) begin
          @(negedge clk);
          if (txd !== 1'b0 || busy !== 1'b1 || ack0 || ack1) stall_err++;
        end
        @(posedge clk);
        tick_run = 1'b1;
        check("stall_hold", 32'(stall_err), 32'd0);
      end
    end
    check("frame_bits", 32'(bit_err), 32'd0);
    check("frame_ack_quiet", 32'(ack_err), 32'd0);
    check("frame_busy", 32'(busy_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin : main
    logic [DB-1:0] d, d1;
    int carry, win;

    do_reset();

    // single byte from requester 0
    set_req(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 1'b0, -1, '0, -1, -1);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_txd", 32'(txd), 32'd1);
    check("single_grant", 32'(grant), 32'd0);

    // tie from reset: alternate 0x11, 0x22, back to back
    do_reset();
    set_req(0, 8'h11);
    set_req(1, 8'h22);
    run_frame(0, 8'h11, 1'b0, 1'b1, -1, '0, -1, -1);
    run_frame(1, 8'h22, 1'b1, 1'b1, -1, '0, -1, -1);
    run_frame(0, 8'h11, 1'b1, 1'b0, -1, '0, -1, -1);
    run_frame(1, 8'h22, 1'b1, 1'b0, -1, '0, -1, -1);
    check("tie_idle_busy", 32'(busy), 32'd0);
    check("tie_grant", 32'(grant), 32'd1);

    // request 1 raised during data bit 2 of a requester-0 frame
    d  = DB'($urandom);
    d1 = DB'($urandom);
    set_req(0, d);
    run_frame(0, d, 1'b0, 1'b0, 3 * B, d1, -1, -1);
    run_frame(1, d1, 1'b1, 1'b0, -1, '0, -1, -1);

    // tick stalled during the start bit
    d = DB'($urandom);
    set_req(0, d);
    run_frame(0, d, 1'b0, 1'b0, -1, '0, TP, -1);
    check("stall_idle_busy", 32'(busy), 32'd0);

    // reset inside the 4th data bit, then a clean tie goes to requester 0
    d = DB'($urandom);
    set_req(0, d);
    run_frame(0, d, 1'b0, 1'b0, -1, '0, -1, 4 * B + B / 2);
    d  = DB'($urandom);
    d1 = DB'($urandom);
    set_req(0, d);
    set_req(1, d1);
    run_frame(0, d, 1'b0, 1'b0, -1, '0, -1, -1);
    run_frame(1, d1, 1'b1, 1'b0, -1, '0, -1, -1);

    // random traffic; winner taken from the request set seen at the decision point
    for (int it = 0; it < 14; it++) begin
      carry = req0 ? 0 : (req1 ? 1 : -1);
      if (carry < 0) begin
        check("rand_idle_busy", 32'(busy), 32'd0);
        check("rand_idle_txd", 32'(txd), 32'd1);
      end
      if (!req0 && $urandom_range(0, 1) == 1) set_req(0, DB'($urandom));
      if (!req1 && $urandom_range(0, 1) == 1) set_req(1, DB'($urandom));
      if (!req0 && !req1) set_req(int'($urandom_range(0, 1)), DB'($urandom));
      if (carry >= 0)         win = carry;
      else if (req0 && req1)  win = 1 - prev_src;
      else                    win = req1 ? 1 : 0;
      run_frame(win, (win != 0) ? data1 : data0, carry >= 0, 1'b0, -1, '0, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
